branch: RTL and testbench
=========================

BRANCH -- requirements
Module: branch

Interface
REQ-001 The block SHALL have exactly one clock and one reset: reset is synchronous and active-high.
REQ-002 clk  input  1  clock; the only clock; the ra register updates on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 opcode  input  3  instruction opcode; 3'b011 marks a branch-class instruction.
REQ-005 fcode  input  4  branch function code.
REQ-006 label  input  25  absolute branch target; only label[9:0] is used.
REQ-007 carryFlag, zFlag, overflowFlag, signFlag  input  1 each  ALU status flags.
REQ-008 PC  input  10  address of the current instruction.
REQ-009 exNPC  output  10  next PC computed by the branch unit.
REQ-010 PCSrc  output  1  1 = take exNPC as a redirect; 0 = sequential fetch.
REQ-011 ra  output  32  return-address register, driven directly from the internal flop.

Function
REQ-012 exNPC and PCSrc SHALL be combinational with zero-cycle latency from all inputs and from the ra register.
REQ-013 Branch decode SHALL apply only when opcode==3'b011; for any other opcode: PCSrc=0, exNPC=PC+1, ra unchanged.
REQ-014 fcode map with opcode 3'b011, taken when the condition holds:
 0000 b: always; 0001 bz: zFlag=1; 0010 bnz: zFlag=0;
 0011 bcy: carryFlag=1; 0100 bncy: carryFlag=0;
 0101 bs: signFlag=1; 0110 bns: signFlag=0;
 0111 bv: overflowFlag=1; 1000 bnv: overflowFlag=0;
 1001 call: always; 1010 ret: always.
REQ-015 Taken b, conditional branch or call: PCSrc=1, exNPC=label[9:0]; label[24:10] ignored.
REQ-016 Taken ret: PCSrc=1, exNPC=ra[9:0].
REQ-017 Not taken, or fcode 1011-1111 (reserved, never taken): PCSrc=0, exNPC=PC+1.
REQ-018 PC+1 SHALL be a 10-bit modulo add: PC=1023 gives 0.
REQ-019 Call with rst=0: on the next rising clk edge, ra becomes {22'b0, PC+1 (10-bit)}.
REQ-020 ra SHALL hold its value on every other cycle, including ret and non-branch cycles.
REQ-021 ret in the cycle after a call SHALL see the updated ra (register read after the edge).

Reset
REQ-022 rst=1 at a rising clk edge SHALL set ra to 32'd0; reset takes priority over a concurrent call.
REQ-023 While rst=1: PCSrc=0 and exNPC=PC+1, regardless of opcode and fcode.
REQ-024 After rst deasserts, ret before any call SHALL give exNPC=0 and PCSrc=1.

Structure
REQ-025 Shared package SHALL hold: OP_BRANCH=3'b011 and the fcode constants (B, BZ, BNZ, BCY, BNCY, BS, BNS, BV, BNV, CALL, RET).
REQ-026 One sub-module, branch_cond: a combinational flag/fcode condition evaluator that outputs "taken".
REQ-027 The ra flop and next-PC mux SHALL reside in branch itself.

Verification
REQ-028 Sequence (each step checked before the next):
 - rst pulse -> ra=0.
 - opcode=011, fcode=1001, label=150, PC=120, V=1, S=1 -> PCSrc=1, exNPC=150; after next edge ra=121.
 - Then fcode=0000, label=150, PC=0 -> PCSrc=1, exNPC=150, ra stays 121.
 - Then fcode=1010, PC=120 -> PCSrc=1, exNPC=121.
REQ-029 opcode=011, fcode=0001, label=150, PC=5:
 - zFlag=0 -> PCSrc=0, exNPC=6.
 - zFlag=1 -> PCSrc=1, exNPC=150.
 - Repeat for the 0010-1000 pairs with the matching flags.
REQ-030 opcode=000, fcode=1001, PC=1023 -> PCSrc=0, exNPC=0, ra unchanged after the edge.
REQ-031 opcode=011, fcode=1100 -> PCSrc=0, exNPC=PC+1.
REQ-032 call asserted in the same cycle as rst=1 -> ra=0 after the edge; PCSrc=0 during reset.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared opcode/fcode encodings and the sequential-PC helper for the branch unit.
package branch_pkg;

   localparam logic [2:0] OP_BRANCH = 3'b011;

   localparam logic [3:0] B    = 4'b0000;
   localparam logic [3:0] BZ   = 4'b0001;
   localparam logic [3:0] BNZ  = 4'b0010;
   localparam logic [3:0] BCY  = 4'b0011;
   localparam logic [3:0] BNCY = 4'b0100;
   localparam logic [3:0] BS   = 4'b0101;
   localparam logic [3:0] BNS  = 4'b0110;
   localparam logic [3:0] BV   = 4'b0111;
   localparam logic [3:0] BNV  = 4'b1000;
   localparam logic [3:0] CALL = 4'b1001;
   localparam logic [3:0] RET  = 4'b1010;

   // 10-bit wrap-around increment: 1023 + 1 gives 0.
   function automatic logic [9:0] pc_inc(input logic [9:0] pc);
      return pc + 10'd1;
   endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational evaluator: decides whether a branch-class fcode is taken given the ALU flags.
module branch_cond
   import branch_pkg::*;
(
   input  logic [3:0] fcode_i,
   input  logic       carry_i,
   input  logic       zero_i,
   input  logic       overflow_i,
   input  logic       sign_i,
   output logic       taken_o
);

   always_comb begin
      // NOTE: default first so every path assigns taken_o and no latch is inferred.
      taken_o = 1'b0;
      case (fcode_i)
         B, CALL, RET: taken_o = 1'b1;
         BZ:           taken_o = zero_i;
         BNZ:          taken_o = !zero_i;
         BCY:          taken_o = carry_i;
         BNCY:         taken_o = !carry_i;
         BS:           taken_o = sign_i;
         BNS:          taken_o = !sign_i;
         BV:           taken_o = overflow_i;
         BNV:          taken_o = !overflow_i;
         default:      taken_o = 1'b0;   // reserved 1011-1111 never branch
      endcase
   end

endmodule

// File: rtl/branch.sv
// Branch unit: next-PC selection and the return-address register written by call.
module branch
   import branch_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  opcode,
   input  logic [3:0]  fcode,
   input  logic [24:0] label,
   input  logic        carryFlag,
   input  logic        zFlag,
   input  logic        overflowFlag,
   input  logic        signFlag,
   input  logic [9:0]  PC,
   output logic [9:0]  exNPC,
   output logic        PCSrc,
   output logic [31:0] ra
);

   logic [31:0] ra_q;
   logic [31:0] ra_d;
   logic [9:0]  pc_seq;
   logic        is_branch;
   logic        taken;
   logic        unused_label_hi;

   // Only the low 10 bits of the target address are meaningful on this core.
   assign unused_label_hi = ^label[24:10];

   assign pc_seq    = pc_inc(PC);
   assign is_branch = !rst && (opcode == OP_BRANCH);

   branch_cond u_cond (
      .fcode_i    (fcode),
      .carry_i    (carryFlag),
      .zero_i     (zFlag),
      .overflow_i (overflowFlag),
      .sign_i     (signFlag),
      .taken_o    (taken)
   );

   always_comb begin
      ra_d = ra_q;
      if (is_branch && (fcode == CALL)) ra_d = {22'b0, pc_seq};
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignment for state; reset wins over a concurrent call.
      if (rst) ra_q <= 32'd0;
      else     ra_q <= ra_d;
   end

   always_comb begin
      PCSrc = 1'b0;
      exNPC = pc_seq;
      if (is_branch && taken) begin
         PCSrc = 1'b1;
         exNPC = (fcode == RET) ? ra_q[9:0] : label[9:0];
      end
   end

   assign ra = ra_q;

endmodule

// File: tb/tb_branch.sv
// Self-checking bench for the branch unit: vector table plus hand-written call/ret/reset sequences.
module tb_branch;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  opcode;
   logic [3:0]  fcode;
   logic [24:0] label;
   logic        carryFlag, zFlag, overflowFlag, signFlag;
   logic [9:0]  PC;
   logic [9:0]  exNPC;
   logic        PCSrc;
   logic [31:0] ra;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      string      name;
      logic       src;
      logic [9:0] npc;
   } exp_t;

   exp_t sb_q[$];

   typedef struct {
      string      name;
      logic [2:0] op;
      logic [3:0] fc;
      logic       c, z, v, s;
      logic [9:0] pc;
      logic       exp_src;
      logic [9:0] exp_npc;
   } vec_t;

   branch dut (
      .clk          (clk),
      .rst          (rst),
      .opcode       (opcode),
      .fcode        (fcode),
      .label        (label),
      .carryFlag    (carryFlag),
      .zFlag        (zFlag),
      .overflowFlag (overflowFlag),
      .signFlag     (signFlag),
      .PC           (PC),
      .exNPC        (exNPC),
      .PCSrc        (PCSrc),
      .ra           (ra)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Drive one instruction just after a rising edge and queue its expected outputs.
   task automatic drive(input string name, input logic r, input logic [2:0] op, input logic [3:0] fc,
                        input logic [24:0] lbl, input logic c, input logic z, input logic v,
                        input logic s, input logic [9:0] pc, input logic e_src, input logic [9:0] e_npc);
      exp_t e;
      rst = r; opcode = op; fcode = fc; label = lbl;
      carryFlag = c; zFlag = z; overflowFlag = v; signFlag = s; PC = pc;
      e.name = name; e.src = e_src; e.npc = e_npc;
      sb_q.push_back(e);
   endtask

   // Let combinational outputs settle, compare against the oldest queued entry, then cross an edge.
   task automatic sample_and_step();
      exp_t e;
      #3;
      if (sb_q.size() == 0) begin
         n_cmp++; n_err++;
         $display("FAIL scoreboard: queue empty, got PCSrc=%0d exNPC=%0d", PCSrc, exNPC);
      end else begin
         e = sb_q.pop_front();
         check({e.name, ".PCSrc"}, {31'b0, PCSrc}, {31'b0, e.src});
         check({e.name, ".exNPC"}, {22'b0, exNPC}, {22'b0, e.npc});
      end
      @(posedge clk); #1;
   endtask

   localparam logic [24:0] LBL = {15'h5A5A, 10'd150};

   vec_t vecs[$];

   initial begin
      vecs = '{
         '{"bz_z0",   3'b011, 4'b0001, 1, 0, 1, 1, 10'd5, 0, 10'd6},
         '{"bz_z1",   3'b011, 4'b0001, 0, 1, 0, 0, 10'd5, 1, 10'd150},
         '{"bnz_z0",  3'b011, 4'b0010, 1, 0, 1, 1, 10'd5, 1, 10'd150},
         '{"bnz_z1",  3'b011, 4'b0010, 0, 1, 0, 0, 10'd5, 0, 10'd6},
         '{"bcy_c0",  3'b011, 4'b0011, 0, 1, 1, 1, 10'd5, 0, 10'd6},
         '{"bcy_c1",  3'b011, 4'b0011, 1, 0, 0, 0, 10'd5, 1, 10'd150},
         '{"bncy_c0", 3'b011, 4'b0100, 0, 1, 1, 1, 10'd5, 1, 10'd150},
         '{"bncy_c1", 3'b011, 4'b0100, 1, 0, 0, 0, 10'd5, 0, 10'd6},
         '{"bs_s0",   3'b011, 4'b0101, 1, 1, 1, 0, 10'd5, 0, 10'd6},
         '{"bs_s1",   3'b011, 4'b0101, 0, 0, 0, 1, 10'd5, 1, 10'd150},
         '{"bns_s0",  3'b011, 4'b0110, 1, 1, 1, 0, 10'd5, 1, 10'd150},
         '{"bns_s1",  3'b011, 4'b0110, 0, 0, 0, 1, 10'd5, 0, 10'd6},
         '{"bv_v0",   3'b011, 4'b0111, 1, 1, 0, 1, 10'd5, 0, 10'd6},
         '{"bv_v1",   3'b011, 4'b0111, 0, 0, 1, 0, 10'd5, 1, 10'd150},
         '{"bnv_v0",  3'b011, 4'b1000, 1, 1, 0, 1, 10'd5, 1, 10'd150},
         '{"bnv_v1",  3'b011, 4'b1000, 0, 0, 1, 0, 10'd5, 0, 10'd6},
         '{"rsv_1011",3'b011, 4'b1011, 1, 1, 1, 1, 10'd5, 0, 10'd6},
         '{"rsv_1100",3'b011, 4'b1100, 1, 1, 1, 1, 10'd40, 0, 10'd41},
         '{"rsv_1111",3'b011, 4'b1111, 0, 0, 0, 0, 10'd5, 0, 10'd6},
         '{"nop_call",3'b000, 4'b1001, 0, 0, 0, 0, 10'd1023, 0, 10'd0},
         '{"op7_b",   3'b111, 4'b0000, 1, 1, 1, 1, 10'd200, 0, 10'd201},
         '{"op2_ret", 3'b010, 4'b1010, 0, 0, 0, 0, 10'd9, 0, 10'd10}
      };

      // Reset: outputs forced sequential even for a taken branch opcode.
      @(posedge clk); #1;
      drive("rst_b", 1, 3'b011, 4'b0000, LBL, 0, 0, 0, 0, 10'd7, 0, 10'd8);
      sample_and_step();
      check("ra_after_rst", ra, 32'd0);

      drive("call", 0, 3'b011, 4'b1001, LBL, 0, 0, 1, 1, 10'd120, 1, 10'd150);
      sample_and_step();
      check("ra_after_call", ra, 32'd121);

      drive("b_pc0", 0, 3'b011, 4'b0000, LBL, 0, 0, 0, 0, 10'd0, 1, 10'd150);
      sample_and_step();
      check("ra_after_b", ra, 32'd121);

      drive("ret", 0, 3'b011, 4'b1010, LBL, 0, 0, 0, 0, 10'd120, 1, 10'd121);
      sample_and_step();
      check("ra_after_ret", ra, 32'd121);

      foreach (vecs[i]) begin
         drive(vecs[i].name, 0, vecs[i].op, vecs[i].fc, LBL, vecs[i].c, vecs[i].z,
               vecs[i].v, vecs[i].s, vecs[i].pc, vecs[i].exp_src, vecs[i].exp_npc);
         sample_and_step();
         check({vecs[i].name, ".ra_hold"}, ra, 32'd121);
      end

      // Call concurrent with reset: reset wins, no redirect.
      drive("rst_call", 1, 3'b011, 4'b1001, LBL, 0, 0, 0, 0, 10'd300, 0, 10'd301);
      sample_and_step();
      check("ra_rst_call", ra, 32'd0);

      drive("ret_no_call", 0, 3'b011, 4'b1010, LBL, 0, 0, 0, 0, 10'd77, 1, 10'd0);
      sample_and_step();

      // Back-to-back call then ret must see the freshly written ra.
      drive("call_1022", 0, 3'b011, 4'b1001, {15'h7FFF, 10'd5}, 0, 0, 0, 0, 10'd1022, 1, 10'd5);
      sample_and_step();
      check("ra_call_1022", ra, 32'd1023);
      drive("ret_b2b", 0, 3'b011, 4'b1010, LBL, 0, 0, 0, 0, 10'd5, 1, 10'd1023);
      sample_and_step();
      check("ra_after_ret_b2b", ra, 32'd1023);

      // Call at the top of the address space wraps the return address to 0.
      drive("call_1023", 0, 3'b011, 4'b1001, LBL, 0, 0, 0, 0, 10'd1023, 1, 10'd150);
      sample_and_step();
      check("ra_call_wrap", ra, 32'd0);

      if (sb_q.size() != 0) begin
         n_cmp++; n_err++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
